// File: rtl/s2qed_lockstep_checker.sv
// s2qed_lockstep_checker
// Runtime lockstep checker for two mriscvcore instances running a register-mapped
// duplicate instruction stream. Core-0 register-write commits are buffered in a
// skew FIFO; each core-1 commit pops the oldest entry and is compared against it,
// with the core-1 destination index translated through the selected register map.
// The first failure is captured and held until clr_err.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   enable               arms the checker (IDLE -> RUN, RUN -> IDLE when low)
//   clr_err              clears the failure state, captured fields and checked
//   c0_* / c1_*          writeback commit port of core 0 / core 1
//   mismatch             sticky failure flag
//   err_code             cause of first failure (1 rd/data, 2 overflow,
//                        3 underflow, 4 timeout, 5 we mismatch)
//   err_rd0/1, err_data0/1  captured destination indices and write data
//   pending              skew FIFO occupancy
//   checked              saturating count of passing compares
module s2qed_lockstep_checker #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAP_MODE = 1,
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         enable,
   input  logic                         clr_err,
   input  logic                         c0_valid,
   input  logic                         c0_we,
   input  logic [4:0]                   c0_rd,
   input  logic [XLEN-1:0]              c0_wdata,
   input  logic                         c1_valid,
   input  logic                         c1_we,
   input  logic [4:0]                   c1_rd,
   input  logic [XLEN-1:0]              c1_wdata,
   output logic                         mismatch,
   output logic [2:0]                   err_code,
   output logic [4:0]                   err_rd0,
   output logic [4:0]                   err_rd1,
   output logic [XLEN-1:0]              err_data0,
   output logic [XLEN-1:0]              err_data1,
   output logic [$clog2(DEPTH+1)-1:0]   pending,
   output logic [CNT_W-1:0]             checked
);

   localparam int unsigned PEND_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned ENT_W  = XLEN + 6;

   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_DATA  = 3'd1;
   localparam logic [2:0] E_OVFL  = 3'd2;
   localparam logic [2:0] E_UNFL  = 3'd3;
   localparam logic [2:0] E_TMO   = 3'd4;
   localparam logic [2:0] E_WE    = 3'd5;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAIL} state_t;

   // Core-1 index expected for a core-0 destination index.
   function automatic logic [4:0] map_rd(input logic [4:0] rd);
      logic [4:0] r;
      r = rd;
      if (MAP_MODE == 1) begin
         if (rd >= 5'd1 && rd <= 5'd11)       r = 5'(5'd13 - rd);
         else if (rd == 5'd12)                r = 5'd13;
         else if (rd == 5'd13)                r = 5'd1;
         else if (rd >= 5'd14 && rd <= 5'd30) r = 5'(6'd44 - {1'b0, rd});
      end
      return r;
   endfunction

   // FIFO pointer advance, wrapping modulo DEPTH.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
   endfunction

   state_t              state_q, state_d;
   logic [ENT_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [PEND_W-1:0]   cnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0]    checked_d;
   logic                mismatch_d;
   logic [2:0]          code_d;
   logic [4:0]          rd0_d, rd1_d;
   logic [XLEN-1:0]     d0_d, d1_d;
   logic                push_en;

   logic [ENT_W-1:0]    head;
   logic                empty, full, cmp, bypass, pop;
   logic                underflow, overflow, we_err, rd_err, tmo_err;
   logic                cmp_we;
   logic [4:0]          cmp_rd;
   logic [XLEN-1:0]     cmp_data;
   logic [2:0]          err_sel;

   // Reference entry: FIFO head, or the core-0 inputs on a same-cycle bypass.
   assign head     = mem[rd_q];
   assign empty    = (pending == '0);
   assign full     = (pending == PEND_W'(DEPTH));
   assign cmp      = c1_valid && (!empty || c0_valid);
   assign bypass   = cmp && empty;
   assign pop      = c1_valid && !empty;
   assign cmp_we   = empty ? c0_we    : head[ENT_W-1];
   assign cmp_rd   = empty ? c0_rd    : head[XLEN +: 5];
   assign cmp_data = empty ? c0_wdata : head[XLEN-1:0];

   // Error sources; x0 write data is never compared.
   assign underflow = c1_valid && empty && !c0_valid;
   assign overflow  = c0_valid && full && !c1_valid;
   assign we_err    = cmp && (cmp_we != c1_we);
   assign rd_err    = cmp && cmp_we &&
                      ((c1_rd != map_rd(cmp_rd)) ||
                       ((cmp_rd != 5'd0) && (c1_wdata != cmp_data)));
   assign tmo_err   = !empty && !c1_valid && (tmo_q == TMO_W'(TIMEOUT - 1));

   // Highest-priority error of this cycle.
   always_comb begin
      err_sel = E_NONE;
      if (underflow)     err_sel = E_UNFL;
      else if (overflow) err_sel = E_OVFL;
      else if (we_err)   err_sel = E_WE;
      else if (rd_err)   err_sel = E_DATA;
      else if (tmo_err)  err_sel = E_TMO;
   end

   // Next-state, FIFO control and capture logic.
   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      cnt_d      = pending;
      tmo_d      = tmo_q;
      checked_d  = checked;
      mismatch_d = mismatch;
      code_d     = err_code;
      rd0_d      = err_rd0;
      rd1_d      = err_rd1;
      d0_d       = err_data0;
      d1_d       = err_data1;
      push_en    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (clr_err) checked_d = '0;
            if (enable)  state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (err_sel != E_NONE) begin
               state_d    = ST_FAIL;
               mismatch_d = 1'b1;
               code_d     = err_sel;
               rd0_d      = '0;
               d0_d       = '0;
               rd1_d      = '0;
               d1_d       = '0;
               case (err_sel)
                  E_OVFL: begin
                     rd0_d = c0_rd;
                     d0_d  = c0_wdata;
                  end
                  E_UNFL: begin
                     rd1_d = c1_rd;
                     d1_d  = c1_wdata;
                  end
                  E_TMO: begin
                     rd0_d = head[XLEN +: 5];
                     d0_d  = head[XLEN-1:0];
                  end
                  default: begin
                     rd0_d = cmp_rd;
                     d0_d  = cmp_data;
                     rd1_d = c1_rd;
                     d1_d  = c1_wdata;
                  end
               endcase
            end else begin
               push_en = c0_valid && !bypass;
               if (push_en) wr_d = ptr_inc(wr_q);
               if (pop)     rd_d = ptr_inc(rd_q);
               if (push_en && !pop)      cnt_d = PEND_W'(pending + 1'b1);
               else if (pop && !push_en) cnt_d = PEND_W'(pending - 1'b1);
               if (cmp && (checked != '1)) checked_d = CNT_W'(checked + 1'b1);
               tmo_d = (c1_valid || empty) ? '0 : TMO_W'(tmo_q + 1'b1);
               if (clr_err) checked_d = '0;
               if (!enable) begin
                  state_d = ST_IDLE;
                  wr_d    = '0;
                  rd_d    = '0;
                  cnt_d   = '0;
                  tmo_d   = '0;
               end
            end
         end
         ST_FAIL: begin
            if (clr_err) begin
               state_d    = ST_IDLE;
               mismatch_d = 1'b0;
               code_d     = '0;
               rd0_d      = '0;
               rd1_d      = '0;
               d0_d       = '0;
               d1_d       = '0;
               checked_d  = '0;
               wr_d       = '0;
               rd_d       = '0;
               cnt_d      = '0;
               tmo_d      = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         wr_q      <= '0;
         rd_q      <= '0;
         tmo_q     <= '0;
         pending   <= '0;
         checked   <= '0;
         mismatch  <= 1'b0;
         err_code  <= '0;
         err_rd0   <= '0;
         err_rd1   <= '0;
         err_data0 <= '0;
         err_data1 <= '0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         tmo_q     <= tmo_d;
         pending   <= cnt_d;
         checked   <= checked_d;
         mismatch  <= mismatch_d;
         err_code  <= code_d;
         err_rd0   <= rd0_d;
         err_rd1   <= rd1_d;
         err_data0 <= d0_d;
         err_data1 <= d1_d;
      end
   end

   // Skew FIFO storage: {we, rd, wdata}.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_q] <= {c0_we, c0_rd, c0_wdata};
   end

endmodule

// File: tb/tb_s2qed_lockstep_checker.sv
// Self-checking bench for s2qed_lockstep_checker (DEPTH=4, MAP_MODE=1, TIMEOUT=8).
// A queue-based reference model tracks the expected outputs; every falling
// edge compares the DUT against it, and directed scenarios add literal checks.
module tb_s2qed_lockstep_checker;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 16;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              enable = 1'b0;
   logic              clr_err = 1'b0;
   logic              c0_valid = 1'b0, c0_we = 1'b0;
   logic [4:0]        c0_rd = '0;
   logic [XLEN-1:0]   c0_wdata = '0;
   logic              c1_valid = 1'b0, c1_we = 1'b0;
   logic [4:0]        c1_rd = '0;
   logic [XLEN-1:0]   c1_wdata = '0;
   logic              mismatch;
   logic [2:0]        err_code;
   logic [4:0]        err_rd0, err_rd1;
   logic [XLEN-1:0]   err_data0, err_data1;
   logic [2:0]        pending;
   logic [CNT_W-1:0]  checked;

   always #5 clk = ~clk;

   s2qed_lockstep_checker #(
      .XLEN(XLEN), .DEPTH(DEPTH), .MAP_MODE(1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .clr_err(clr_err),
      .c0_valid(c0_valid), .c0_we(c0_we), .c0_rd(c0_rd), .c0_wdata(c0_wdata),
      .c1_valid(c1_valid), .c1_we(c1_we), .c1_rd(c1_rd), .c1_wdata(c1_wdata),
      .mismatch(mismatch), .err_code(err_code),
      .err_rd0(err_rd0), .err_rd1(err_rd1),
      .err_data0(err_data0), .err_data1(err_data1),
      .pending(pending), .checked(checked)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit        we;
      bit [4:0]  rd;
      bit [31:0] d;
   } ent_t;

   // Mirror map as a plain lookup table.
   int map_tbl [32] = '{0, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 13, 1,
                        30, 29, 28, 27, 26, 25, 24, 23, 22, 21, 20, 19, 18, 17, 16, 15, 14,
                        31};

   ent_t      q[$];
   int        m_state;   // 0 idle, 1 run, 2 fail
   bit        m_mis;
   bit [2:0]  m_code;
   bit [4:0]  m_rd0, m_rd1;
   bit [31:0] m_d0, m_d1;
   int        m_checked;
   int        m_quiet;
   ent_t      r;
   int        e;
   bit        was_empty;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q.delete();
         m_state = 0; m_mis = 0; m_code = 0;
         m_rd0 = 0; m_rd1 = 0; m_d0 = 0; m_d1 = 0;
         m_checked = 0; m_quiet = 0;
      end else begin
         e = 0;
         case (m_state)
            0: begin
               if (clr_err) m_checked = 0;
               if (enable) m_state = 1;
            end
            1: begin
               if (q.size() > 0) r = q[0];
               else begin r.we = c0_we; r.rd = c0_rd; r.d = c0_wdata; end
               if (c1_valid && q.size() == 0 && !c0_valid) e = 3;
               else if (c0_valid && q.size() == DEPTH && !c1_valid) e = 2;
               else if (c1_valid) begin
                  if (r.we != c1_we) e = 5;
                  else if (r.we && (int'(c1_rd) != map_tbl[r.rd] ||
                                    (r.rd != 0 && r.d != c1_wdata))) e = 1;
               end else if (q.size() > 0 && m_quiet + 1 == TIMEOUT) e = 4;

               if (e != 0) begin
                  m_state = 2; m_mis = 1; m_code = 3'(e);
                  m_rd0 = 0; m_d0 = 0; m_rd1 = 0; m_d1 = 0;
                  if (e == 2) begin m_rd0 = c0_rd; m_d0 = c0_wdata; end
                  else if (e == 3) begin m_rd1 = c1_rd; m_d1 = c1_wdata; end
                  else if (e == 4) begin m_rd0 = r.rd; m_d0 = r.d; end
                  else begin m_rd0 = r.rd; m_d0 = r.d; m_rd1 = c1_rd; m_d1 = c1_wdata; end
               end else begin
                  was_empty = (q.size() == 0);
                  if (c1_valid) begin
                     if (!was_empty) void'(q.pop_front());
                     if (m_checked < 65535) m_checked++;
                  end
                  if (c0_valid && !(c1_valid && was_empty)) begin
                     ent_t n;
                     n.we = c0_we; n.rd = c0_rd; n.d = c0_wdata;
                     q.push_back(n);
                  end
                  m_quiet = (c1_valid || was_empty) ? 0 : m_quiet + 1;
                  if (clr_err) m_checked = 0;
                  if (!enable) begin q.delete(); m_quiet = 0; m_state = 0; end
               end
            end
            default: begin
               if (clr_err) begin
                  m_state = 0; m_mis = 0; m_code = 0;
                  m_rd0 = 0; m_rd1 = 0; m_d0 = 0; m_d1 = 0;
                  m_checked = 0; m_quiet = 0; q.delete();
               end
            end
         endcase
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("mismatch",  64'(mismatch),  64'(m_mis));
         check("err_code",  64'(err_code),  64'(m_code));
         check("err_rd0",   64'(err_rd0),   64'(m_rd0));
         check("err_rd1",   64'(err_rd1),   64'(m_rd1));
         check("err_data0", 64'(err_data0), 64'(m_d0));
         check("err_data1", 64'(err_data1), 64'(m_d1));
         check("pending",   64'(pending),   64'(q.size()));
         check("checked",   64'(checked),   64'(m_checked));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit v0, input bit we0, input logic [4:0] rd0, input logic [31:0] d0,
                      input bit v1, input bit we1, input logic [4:0] rd1, input logic [31:0] d1);
      c0_valid = v0; c0_we = we0; c0_rd = rd0; c0_wdata = d0;
      c1_valid = v1; c1_we = we1; c1_rd = rd1; c1_wdata = d1;
      tick();
      c0_valid = 1'b0; c1_valid = 1'b0;
   endtask

   task automatic push0(input logic [4:0] rd, input logic [31:0] d);
      cyc(1'b1, 1'b1, rd, d, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic pop1(input bit we, input logic [4:0] rd, input logic [31:0] d);
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, we, rd, d);
   endtask

   // Clear the failure, then let the checker re-arm (enable stays high).
   task automatic clear_fail();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_mismatch", 64'(mismatch), 64'd0);
      check("clr_code",     64'(err_code), 64'd0);
      check("clr_pending",  64'(pending),  64'd0);
      check("clr_checked",  64'(checked),  64'd0);
      tick();
   endtask

   initial begin
      logic [4:0]  drain_rd [4];
      logic [31:0] drain_d  [4];

      @(posedge clk);
      chk_en = 1'b1;
      tick();
      check("rst_mismatch", 64'(mismatch), 64'd0);
      check("rst_pending",  64'(pending),  64'd0);
      check("rst_checked",  64'(checked),  64'd0);
      rstn = 1'b1;
      enable = 1'b1;
      tick();

      // Basic mapped match: rd 5 -> 8, three cycles of skew.
      push0(5'd5, 32'hA5A5);
      check("t1_pending1", 64'(pending), 64'd1);
      tick();
      tick();
      pop1(1'b1, 5'd8, 32'hA5A5);
      check("t1_pending0", 64'(pending),  64'd0);
      check("t1_checked",  64'(checked),  64'd1);
      check("t1_mismatch", 64'(mismatch), 64'd0);

      // x0 writes with different data pass.
      push0(5'd0, 32'h1);
      pop1(1'b1, 5'd0, 32'h2);
      check("x0_checked",  64'(checked),  64'd2);
      check("x0_mismatch", 64'(mismatch), 64'd0);

      // Bypass match (rd 3 -> 10), then a we=0 bypass with unrelated rd/data.
      cyc(1'b1, 1'b1, 5'd3, 32'h1234, 1'b1, 1'b1, 5'd10, 32'h1234);
      check("byp_pending", 64'(pending), 64'd0);
      check("byp_checked", 64'(checked), 64'd3);
      cyc(1'b1, 1'b0, 5'd7, 32'h77, 1'b1, 1'b0, 5'd9, 32'h99);
      check("we0_checked", 64'(checked), 64'd4);

      // Full FIFO with simultaneous push/pop, then drain.
      for (int i = 1; i <= 4; i++) push0(5'(i), 32'h100 + 32'(i));
      check("full_pending", 64'(pending), 64'd4);
      cyc(1'b1, 1'b1, 5'd20, 32'h20, 1'b1, 1'b1, 5'd12, 32'h101);
      check("full_sim_pending",  64'(pending),  64'd4);
      check("full_sim_mismatch", 64'(mismatch), 64'd0);
      drain_rd = '{5'd11, 5'd10, 5'd9, 5'd24};
      drain_d  = '{32'h102, 32'h103, 32'h104, 32'h20};
      for (int i = 0; i < 4; i++) pop1(1'b1, drain_rd[i], drain_d[i]);
      check("drain_pending", 64'(pending), 64'd0);
      check("drain_checked", 64'(checked), 64'd9);

      // Overflow on the fifth push.
      for (int i = 1; i <= 4; i++) push0(5'(i), 32'h200 + 32'(i));
      push0(5'd6, 32'h66);
      check("ovf_mismatch", 64'(mismatch),  64'd1);
      check("ovf_code",     64'(err_code),  64'd2);
      check("ovf_rd0",      64'(err_rd0),   64'd6);
      check("ovf_data0",    64'(err_data0), 64'h66);
      check("ovf_rd1",      64'(err_rd1),   64'd0);
      check("ovf_pending",  64'(pending),   64'd4);
      tick();
      tick();
      check("ovf_sticky", 64'(mismatch), 64'd1);
      clear_fail();

      // rd mismatch: rd 13 must map to 1.
      push0(5'd13, 32'h55);
      pop1(1'b1, 5'd13, 32'h55);
      check("rd_mismatch", 64'(mismatch), 64'd1);
      check("rd_code",     64'(err_code), 64'd1);
      check("rd_rd0",      64'(err_rd0),  64'd13);
      check("rd_rd1",      64'(err_rd1),  64'd13);
      cyc(1'b1, 1'b1, 5'd4, 32'h4, 1'b1, 1'b1, 5'd9, 32'h4);
      tick();
      check("fail_hold_code",    64'(err_code), 64'd1);
      check("fail_hold_pending", 64'(pending),  64'd1);
      clear_fail();

      // we mismatch.
      push0(5'd2, 32'h22);
      pop1(1'b0, 5'd11, 32'h22);
      check("we_code",  64'(err_code), 64'd5);
      check("we_rd0",   64'(err_rd0),  64'd2);
      clear_fail();

      // Underflow.
      pop1(1'b1, 5'd7, 32'hBEEF);
      check("unf_code",  64'(err_code),  64'd3);
      check("unf_rd1",   64'(err_rd1),   64'd7);
      check("unf_data1", 64'(err_data1), 64'hBEEF);
      check("unf_rd0",   64'(err_rd0),   64'd0);
      clear_fail();

      // Timeout exactly eight cycles after the push lands.
      push0(5'd9, 32'h99);
      repeat (7) tick();
      check("tmo_early", 64'(mismatch), 64'd0);
      tick();
      check("tmo_mismatch", 64'(mismatch), 64'd1);
      check("tmo_code",     64'(err_code), 64'd4);
      check("tmo_rd0",      64'(err_rd0),  64'd9);
      clear_fail();

      // Disable flushes the FIFO.
      push0(5'd1, 32'h1);
      push0(5'd2, 32'h2);
      enable = 1'b0;
      tick();
      check("dis_pending", 64'(pending), 64'd0);
      enable = 1'b1;
      tick();

      // Asynchronous reset while failing with three entries pending.
      push0(5'd1, 32'h1);
      push0(5'd2, 32'h2);
      push0(5'd3, 32'h3);
      pop1(1'b1, 5'd12, 32'hFF);
      check("pre_rst_pending",  64'(pending),  64'd3);
      check("pre_rst_mismatch", 64'(mismatch), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_mismatch", 64'(mismatch),  64'd0);
      check("arst_code",     64'(err_code),  64'd0);
      check("arst_pending",  64'(pending),   64'd0);
      check("arst_checked",  64'(checked),   64'd0);
      check("arst_rd0",      64'(err_rd0),   64'd0);
      check("arst_data1",    64'(err_data1), 64'd0);
      tick();
      rstn = 1'b1;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/s2qed_lockstep_checker.md
# s2qed_lockstep_checker

Synthesizable runtime checker that compares two `mriscvcore` instances running a register-mapped duplicate instruction stream. It is the parametrised successor of the static S2QED property set. It buffers core-0 register-write commits in a skew FIFO and matches each one against the next core-1 commit, with the core-1 destination index translated through a selectable register map. It sits beside `mriscvcore_top_s2qed`, is driven by each core's writeback port, and reports sticky, captured failures for simulation, emulation and formal cover.

## Interface
Parameters:
- `XLEN`, 32, register data width.
- `DEPTH`, 4, skew FIFO entries; the maximum number of commits core 1 may lag core 0. Any value from 1 upward is legal, including non-power-of-2.
- `MAP_MODE`, 1. 0 = identity map. 1 = S2QED mirror map: 0→0, i→13−i for i=1..11, 12→13, 13→1, i→44−i for i=14..30, 31→31.
- `TIMEOUT`, 64, number of consecutive cycles without a core-1 commit, while the FIFO is non-empty, before an error is raised.
- `CNT_W`, 16, width of the checked-commit counter.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `enable` in 1: arms the checker.
- `clr_err` in 1: clears the failure state.
- `c0_valid` in 1: core-0 commit strobe.
- `c0_we` in 1: core-0 commit writes the register file.
- `c0_rd` in 5: core-0 destination index.
- `c0_wdata` in XLEN: core-0 write data.
- `c1_valid`, `c1_we`, `c1_rd`, `c1_wdata`: same as above, for core 1.
- `mismatch` out 1: sticky failure flag.
- `err_code` out 3: cause of the first failure.
- `err_rd0` out 5, `err_rd1` out 5: captured destination indices.
- `err_data0` out XLEN, `err_data1` out XLEN: captured write data.
- `pending` out $clog2(DEPTH+1): FIFO occupancy.
- `checked` out CNT_W: matched commits, saturating.

## Operation
- FSM states: IDLE, RUN, FAIL.
  - IDLE: FIFO empty; commits are ignored. Goes to RUN when `enable`=1.
  - RUN: goes to IDLE when `enable`=0; the FIFO is flushed and `checked` is held. Goes to FAIL on any error.
  - FAIL: `mismatch`=1. The FIFO is frozen and commits are ignored. Goes to IDLE on `clr_err`, which also zeroes `err_*` and `checked`.
- Push: in RUN, `c0_valid` pushes {we, rd, wdata}.
- Pop: in RUN, `c1_valid` pops the head and compares it. Comparison rules:
  - `we` must be equal.
  - If `we`=1: `c1_rd` must equal map(`rd0`).
  - If `we`=1 and `rd0`≠0: data must be equal. x0 data is ignored.
  - If `we`=0: rd and data are not compared.
- Bypass: a `c1_valid` arriving with the FIFO empty and `c0_valid` in the same cycle compares directly against the core-0 inputs. Nothing is pushed or popped, and `pending` is unchanged.
- Simultaneous push and pop with a non-empty FIFO: the head is compared and the new entry is enqueued. This is legal when the FIFO is full.
- Error codes, in priority order when several occur in the same cycle:
  - 3 underflow: `c1_valid` with the FIFO empty and no `c0_valid`.
  - 2 overflow: `c0_valid` with the FIFO full and no `c1_valid`.
  - 5 we mismatch.
  - 1 rd/data mismatch.
  - 4 timeout.
- Timeout counter: cleared by every `c1_valid` and whenever the FIFO is empty. It increments each RUN cycle while `pending`>0. It fires when it reaches TIMEOUT.
- Captured values on failure:
  - For codes 1 and 5: head (or bypass) rd and data into `err_rd0`/`err_data0`; core-1 inputs into `err_rd1`/`err_data1`.
  - For codes 2, 3 and 4: the values of the offending side are captured; the other side's fields are 0.
- `checked` increments on each passing compare and saturates at 2^CNT_W−1.

## Timing
- Reset values: state IDLE; `mismatch`=0, `err_code`=0, `err_*`=0, `pending`=0, `checked`=0; FIFO pointers 0.
- All outputs are registered. An error detected at edge N is visible after edge N: `mismatch`, `err_code` and `err_*` all update in the same cycle.
- `pending` reflects push and pop one cycle after the commit edge.
- FIFO pointers wrap modulo DEPTH.
- `enable` falling and `clr_err` take effect at the next edge. `clr_err` in RUN or IDLE has no effect besides zeroing `err_*` and `checked`.
- An error and `enable`=0 in the same cycle: FAIL wins.
- Reset asserted mid-operation clears everything immediately, independent of `clk`.

## Test plan
- MAP_MODE=1, enable: c0 commits (we=1, rd=5, data=0xA5A5) → c1 commits (rd=8, data=0xA5A5) three cycles later → `checked`=1, `mismatch`=0, `pending` goes 1 then 0.
- MAP_MODE=1: c0 rd=13, c1 rd=13 (expected 1) → `mismatch`=1 and `err_code`=1 the next cycle, `err_rd0`=13, `err_rd1`=13; state holds in FAIL until `clr_err`.
- DEPTH=4: five c0 commits without any c1 commit → overflow on the fifth, `err_code`=2. Separately, four c0 commits then a simultaneous c0+c1 commit with matching data → no error, `pending` stays 4.
- c1 commit with the FIFO empty → `err_code`=3. A simultaneous c0+c1 commit with the FIFO empty and matching data → bypass pass, `pending`=0, `checked`+1.
- TIMEOUT=8: one c0 commit, no c1 commit → `err_code`=4 exactly eight cycles after the push lands.
- Reset: assert `rstn`=0 with `pending`=3 and FAIL active → all outputs 0 and state IDLE immediately. Also, c0 and c1 writing x0 with different data (we=1, rd=0) → pass.
